spi_conf_regfile: RTL and testbench

//  Parametrised SPI configuration register file for the FPGA top level.

---
 rtl/spi_conf_regfile_pkg.sv | 35 +++
 rtl/spi_sync_edge.sv | 46 ++++
 rtl/spi_conf_regfile.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_conf_regfile.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_conf_regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_conf_regfile_pkg                                            |
// | Purpose  : Shared opcodes, register indices and helpers for the SPI        |
// |            configuration register file.                                    |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package spi_conf_regfile_pkg;

    // Width of the opcode field at the head of every frame.
    localparam int c_OP_W = 4;

    // Frame opcodes; any other 4-bit value is rejected.
    typedef enum logic [c_OP_W-1:0] {
        OP_NOP    = 4'h0,
        OP_WRITE  = 4'h1,
        OP_READ   = 4'h2,
        OP_COMMIT = 4'h3
    } op_e;

    // Register map of the active word.
    localparam int c_CONF_REG = 0;
    localparam int c_DIV_REG  = 1;

    // Rejected-frame counter width.
    localparam int c_ERR_CNT_W = 8;

    // Saturating increment for the rejected-frame counter.
    function automatic logic [c_ERR_CNT_W-1:0] sat_inc(input logic [c_ERR_CNT_W-1:0] v);
        return (v == {c_ERR_CNT_W{1'b1}}) ? v : v + c_ERR_CNT_W'(1);
    endfunction

endpackage : spi_conf_regfile_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_sync_edge                                                   |
// | Purpose  : Two-flop synchroniser for an asynchronous pin, followed by a    |
// |            rise/fall edge detector on the synchronised level.              |
// | Ports    : ck_1356meg  in   sampling clock                                 |
// |            rst         in   synchronous active-high reset                  |
// |            pin_i       in   asynchronous input pin                         |
// |            level_o     out  synchronised level                             |
// |            rise_o      out  1-cycle pulse on synchronised 0->1             |
// |            fall_o      out  1-cycle pulse on synchronised 1->0             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module spi_sync_edge (
    input  logic ck_1356meg,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Edge pulses are combinational so that a pin edge is acted on by the
    // consuming logic at the third clock edge after it.
    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_conf_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_conf_regfile                                                |
// | Purpose  : SPI configuration register file. Oversamples the ARM SPI bus,   |
// |            decodes fixed-length WRITE/READ/COMMIT frames into shadow       |
// |            registers and copies shadow to active only when apply_safe is   |
// |            high, so control changes never glitch the carrier.              |
// | Ports    : ck_1356meg     in   system clock, all logic on posedge          |
// |            rst            in   synchronous active-high reset               |
// |            spck/mosi/ncs  in   asynchronous SPI bus from the ARM           |
// |            miso           out  readback data, changes after spck fall      |
// |            apply_safe     in   active registers may change this cycle      |
// |            conf_active    out  active bank, reg i at [i*DATA_W +: DATA_W]  |
// |            commit_pending out  shadow copy requested, not yet applied      |
// |            frame_err      out  1-cycle pulse on a rejected frame           |
// |            err_cnt        out  saturating rejected-frame count             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module spi_conf_regfile
    import spi_conf_regfile_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int NREGS       = 2,
    parameter int AUTO_COMMIT = 1
) (
    input  logic                    ck_1356meg,
    input  logic                    rst,
    input  logic                    spck,
    input  logic                    mosi,
    input  logic                    ncs,
    output logic                    miso,
    input  logic                    apply_safe,
    output logic [NREGS*DATA_W-1:0] conf_active,
    output logic                    commit_pending,
    output logic                    frame_err,
    output logic [c_ERR_CNT_W-1:0]  err_cnt
);

    localparam int HDR_W   = c_OP_W + ADDR_W;
    localparam int FRAME_W = HDR_W + DATA_W;
    localparam int BCNT_W  = $clog2(FRAME_W + 2);
    localparam int REGS_W  = NREGS * DATA_W;

    localparam logic [BCNT_W-1:0] c_BCNT_FRAME  = BCNT_W'(FRAME_W);
    localparam logic [BCNT_W-1:0] c_BCNT_SAT    = BCNT_W'(FRAME_W + 1);
    localparam logic [BCNT_W-1:0] c_BCNT_HDR_M1 = BCNT_W'(HDR_W - 1);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic spck_rise, spck_fall, spck_level_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic ncs_s, ncs_rise, ncs_fall_unused;

    spi_sync_edge u_sync_spck (
        .ck_1356meg (ck_1356meg),
        .rst        (rst),
        .pin_i      (spck),
        .level_o    (spck_level_unused),
        .rise_o     (spck_rise),
        .fall_o     (spck_fall)
    );

    spi_sync_edge u_sync_mosi (
        .ck_1356meg (ck_1356meg),
        .rst        (rst),
        .pin_i      (mosi),
        .level_o    (mosi_s),
        .rise_o     (mosi_rise_unused),
        .fall_o     (mosi_fall_unused)
    );

    spi_sync_edge u_sync_ncs (
        .ck_1356meg (ck_1356meg),
        .rst        (rst),
        .pin_i      (ncs),
        .level_o    (ncs_s),
        .rise_o     (ncs_rise),
        .fall_o     (ncs_fall_unused)
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W + 1)'(NREGS);
    endfunction

    function automatic logic [DATA_W-1:0] bank_word(input logic [REGS_W-1:0] bank,
                                                    input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (a == ADDR_W'(i)) w = bank[i*DATA_W +: DATA_W];
        end
        return w;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0]     sreg_q,   sreg_d;
    logic [BCNT_W-1:0]      bcnt_q,   bcnt_d;
    logic                   armed_q,  armed_d;
    logic [REGS_W-1:0]      shadow_q, shadow_d;
    logic [REGS_W-1:0]      active_q, active_d;
    logic                   cp_q,     cp_d;
    logic                   ferr_q,   ferr_d;
    logic [c_ERR_CNT_W-1:0] errcnt_q, errcnt_d;
    logic [DATA_W-1:0]      oreg_q,   oreg_d;
    logic                   rd_en_q,  rd_en_d;
    logic                   miso_q,   miso_d;

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            sreg_q   <= '0;
            bcnt_q   <= '0;
            armed_q  <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            cp_q     <= 1'b0;
            ferr_q   <= 1'b0;
            errcnt_q <= '0;
            oreg_q   <= '0;
            rd_en_q  <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            sreg_q   <= sreg_d;
            bcnt_q   <= bcnt_d;
            armed_q  <= armed_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cp_q     <= cp_d;
            ferr_q   <= ferr_d;
            errcnt_q <= errcnt_d;
            oreg_q   <= oreg_d;
            rd_en_q  <= rd_en_d;
            miso_q   <= miso_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive, readback, decode and apply
    // ------------------------------------------------------------------
    logic               rx_active;
    logic [FRAME_W-1:0] shift_word;
    logic [c_OP_W-1:0]  hdr_op,   dec_op;
    logic [ADDR_W-1:0]  hdr_addr, dec_addr;
    logic [DATA_W-1:0]  dec_data;
    logic               dec_reject;

    always_comb begin
        sreg_d   = sreg_q;
        bcnt_d   = bcnt_q;
        armed_d  = armed_q | ncs_s;
        shadow_d = shadow_q;
        active_d = active_q;
        cp_d     = cp_q;
        ferr_d   = 1'b0;
        errcnt_d = errcnt_q;
        oreg_d   = oreg_q;
        rd_en_d  = rd_en_q;
        miso_d   = miso_q;

        rx_active  = ~ncs_s & armed_q;
        shift_word = {sreg_q[FRAME_W-2:0], mosi_s};
        // Header as it will look once the current bit is shifted in.
        hdr_op     = shift_word[HDR_W-1 -: c_OP_W];
        hdr_addr   = shift_word[ADDR_W-1:0];
        dec_op     = sreg_q[FRAME_W-1 -: c_OP_W];
        dec_addr   = sreg_q[DATA_W +: ADDR_W];
        dec_data   = sreg_q[DATA_W-1:0];
        dec_reject = (bcnt_q != c_BCNT_FRAME)
                   || (dec_op > OP_COMMIT)
                   || (((dec_op == OP_WRITE) || (dec_op == OP_READ)) && !addr_ok(dec_addr));

        if (rx_active && spck_rise) begin
            sreg_d = shift_word;
            if (bcnt_q != c_BCNT_SAT) bcnt_d = bcnt_q + BCNT_W'(1);
            // Header complete on this bit: preload the readback word so
            // the first data bit can go out on the very next spck fall.
            if ((bcnt_q == c_BCNT_HDR_M1) && (hdr_op == OP_READ) && addr_ok(hdr_addr)) begin
                oreg_d  = bank_word(shadow_q, hdr_addr);
                rd_en_d = 1'b1;
            end
        end

        if (rx_active && spck_fall && rd_en_q) begin
            miso_d = oreg_q[DATA_W-1];
            oreg_d = {oreg_q[DATA_W-2:0], 1'b0};
        end

        // Apply uses the pre-cycle shadow; a decode below may re-arm cp.
        if (cp_q && apply_safe) begin
            active_d = shadow_q;
            cp_d     = 1'b0;
        end

        if (ncs_rise) begin
            miso_d  = 1'b0;
            rd_en_d = 1'b0;
            sreg_d  = '0;
            bcnt_d  = '0;
            // A frame started before the last reset never armed; drop it.
            if (armed_q) begin
                if (dec_reject) begin
                    ferr_d   = 1'b1;
                    errcnt_d = sat_inc(errcnt_q);
                end else if (dec_op == OP_WRITE) begin
                    for (int i = 0; i < NREGS; i++) begin
                        if (dec_addr == ADDR_W'(i)) shadow_d[i*DATA_W +: DATA_W] = dec_data;
                    end
                    if (AUTO_COMMIT != 0) cp_d = 1'b1;
                end else if (dec_op == OP_COMMIT) begin
                    cp_d = 1'b1;
                end
            end
        end
    end

    assign miso           = miso_q;
    assign conf_active    = active_q;
    assign commit_pending = cp_q;
    assign frame_err      = ferr_q;
    assign err_cnt        = errcnt_q;

endmodule : spi_conf_regfile
`default_nettype wire

// File: tb/tb_spi_conf_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_conf_regfile                                             |
// | Purpose  : Directed self-checking bench for spi_conf_regfile. Unit A uses  |
// |            AUTO_COMMIT=1, unit B AUTO_COMMIT=0; one SPI master is steered  |
// |            to either unit.                                                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_spi_conf_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, spck, mosi, ncs, apply_safe, sel_b;
    logic spck_a, ncs_a, spck_b, ncs_b;

    assign spck_a = sel_b ? 1'b0 : spck;
    assign ncs_a  = sel_b ? 1'b1 : ncs;
    assign spck_b = sel_b ? spck : 1'b0;
    assign ncs_b  = sel_b ? ncs  : 1'b1;

    logic        miso_a, cp_a, ferr_a, miso_b, cp_b, ferr_b;
    logic [15:0] act_a, act_b;
    logic [7:0]  errc_a, errc_b;

    spi_conf_regfile #(.DATA_W(8), .ADDR_W(4), .NREGS(2), .AUTO_COMMIT(1)) u_dut_a (
        .ck_1356meg     (clk),
        .rst            (rst),
        .spck           (spck_a),
        .mosi           (mosi),
        .ncs            (ncs_a),
        .miso           (miso_a),
        .apply_safe     (apply_safe),
        .conf_active    (act_a),
        .commit_pending (cp_a),
        .frame_err      (ferr_a),
        .err_cnt        (errc_a)
    );

    spi_conf_regfile #(.DATA_W(8), .ADDR_W(4), .NREGS(2), .AUTO_COMMIT(0)) u_dut_b (
        .ck_1356meg     (clk),
        .rst            (rst),
        .spck           (spck_b),
        .mosi           (mosi),
        .ncs            (ncs_b),
        .miso           (miso_b),
        .apply_safe     (apply_safe),
        .conf_active    (act_b),
        .commit_pending (cp_b),
        .frame_err      (ferr_b),
        .err_cnt        (errc_b)
    );

    int          checks = 0;
    int          passed = 0;
    int          err_pulses;
    logic [15:0] snap5;
    logic [31:0] rx;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift n bits MSB first; miso is captured just before each spck rise.
    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            spck = 1'b0;
            wait_clk(5);
            rx   = {rx[30:0], (sel_b ? miso_b : miso_a)};
            spck = 1'b1;
            wait_clk(5);
        end
        spck = 1'b0;
        wait_clk(2);
    endtask

    // Raise ncs and watch 10 cycles: count frame_err pulses and keep the
    // active bank as seen 5 cycles after the pin edge.
    task automatic end_frame();
        ncs        = 1'b1;
        err_pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            wait_clk(1);
            if ((sel_b ? ferr_b : ferr_a) === 1'b1) err_pulses++;
            if (c == 5) snap5 = sel_b ? act_b : act_a;
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n);
        ncs = 1'b0;
        rx  = '0;
        wait_clk(4);
        shift_bits(bits, n);
        end_frame();
    endtask

    task automatic test_reset();
        checks++; if (act_a !== 16'h0000) $display("FAIL reset_act_a: got %h expected %h", act_a, 16'h0); else passed++;
        checks++; if (cp_a !== 1'b0)      $display("FAIL reset_cp_a: got %b expected 0", cp_a); else passed++;
        checks++; if (ferr_a !== 1'b0)    $display("FAIL reset_ferr_a: got %b expected 0", ferr_a); else passed++;
        checks++; if (errc_a !== 8'h00)   $display("FAIL reset_errc_a: got %h expected 00", errc_a); else passed++;
        checks++; if (miso_a !== 1'b0)    $display("FAIL reset_miso_a: got %b expected 0", miso_a); else passed++;
        checks++; if (act_b !== 16'h0000) $display("FAIL reset_act_b: got %h expected %h", act_b, 16'h0); else passed++;
        checks++; if (cp_b !== 1'b0)      $display("FAIL reset_cp_b: got %b expected 0", cp_b); else passed++;
        checks++; if (errc_b !== 8'h00)   $display("FAIL reset_errc_b: got %h expected 00", errc_b); else passed++;
    endtask

    task automatic test_auto_write();
        send_frame(32'h10A5, 16);
        checks++; if (snap5[7:0] !== 8'hA5) $display("FAIL auto_write_5cyc: got %h expected A5", snap5[7:0]); else passed++;
        checks++; if (err_pulses !== 0)     $display("FAIL auto_write_ferr: got %0d expected 0", err_pulses); else passed++;
        checks++; if (cp_a !== 1'b0)        $display("FAIL auto_write_cp: got %b expected 0", cp_a); else passed++;
    endtask

    task automatic test_manual_commit();
        sel_b      = 1'b1;
        apply_safe = 1'b0;
        send_frame(32'h1133, 16);
        checks++; if (cp_b !== 1'b0) $display("FAIL manual_no_autocommit: got %b expected 0", cp_b); else passed++;
        send_frame(32'h3000, 16);
        checks++; if (cp_b !== 1'b1)      $display("FAIL manual_cp_held: got %b expected 1", cp_b); else passed++;
        checks++; if (act_b !== 16'h0000) $display("FAIL manual_act_held: got %h expected 0000", act_b); else passed++;
        apply_safe = 1'b1;
        wait_clk(1);
        checks++; if (act_b[15:8] !== 8'h33) $display("FAIL manual_apply: got %h expected 33", act_b[15:8]); else passed++;
        checks++; if (cp_b !== 1'b0)         $display("FAIL manual_cp_clear: got %b expected 0", cp_b); else passed++;
        sel_b = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_rejects();
        send_frame(32'h11EE >> 1, 15);
        checks++; if (err_pulses !== 1) $display("FAIL rej_short_pulse: got %0d expected 1", err_pulses); else passed++;
        send_frame(32'h1512, 16);
        checks++; if (err_pulses !== 1) $display("FAIL rej_addr_pulse: got %0d expected 1", err_pulses); else passed++;
        send_frame(32'h7000, 16);
        checks++; if (err_pulses !== 1) $display("FAIL rej_op_pulse: got %0d expected 1", err_pulses); else passed++;
        checks++; if (errc_a !== 8'd3)  $display("FAIL rej_count: got %0d expected 3", errc_a); else passed++;
        send_frame(32'h3000, 16);
        checks++; if (act_a !== 16'h00A5) $display("FAIL rej_shadow: got %h expected 00A5", act_a); else passed++;
        checks++; if (cp_a !== 1'b0)      $display("FAIL rej_cp: got %b expected 0", cp_a); else passed++;
    endtask

    task automatic test_readback();
        send_frame(32'h115A, 16);
        checks++; if (act_a !== 16'h5AA5) $display("FAIL rd_setup: got %h expected 5AA5", act_a); else passed++;
        send_frame(32'h2100, 16);
        checks++; if (rx[7:0] !== 8'h5A)  $display("FAIL rd_reg1_data: got %h expected 5A", rx[7:0]); else passed++;
        checks++; if (rx[15:8] !== 8'h00) $display("FAIL rd_reg1_hdr: got %h expected 00", rx[15:8]); else passed++;
        checks++; if (miso_a !== 1'b0)    $display("FAIL rd_miso_idle: got %b expected 0", miso_a); else passed++;
        checks++; if (err_pulses !== 0)   $display("FAIL rd_ferr: got %0d expected 0", err_pulses); else passed++;
        send_frame(32'h2000, 16);
        checks++; if (rx[7:0] !== 8'hA5)  $display("FAIL rd_reg0_data: got %h expected A5", rx[7:0]); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        ncs = 1'b0;
        rx  = '0;
        wait_clk(4);
        shift_bits(32'h1077 >> 10, 6);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        shift_bits(32'h1077 & 32'h3FF, 10);
        end_frame();
        checks++; if (err_pulses !== 0)   $display("FAIL rstmid_ferr: got %0d expected 0", err_pulses); else passed++;
        checks++; if (errc_a !== 8'h00)   $display("FAIL rstmid_errc: got %h expected 00", errc_a); else passed++;
        checks++; if (act_a !== 16'h0000) $display("FAIL rstmid_act: got %h expected 0000", act_a); else passed++;
        checks++; if (cp_a !== 1'b0)      $display("FAIL rstmid_cp: got %b expected 0", cp_a); else passed++;
        send_frame(32'h10C3, 16);
        checks++; if (act_a !== 16'h00C3) $display("FAIL rstmid_next: got %h expected 00C3", act_a); else passed++;
        checks++; if (err_pulses !== 0)   $display("FAIL rstmid_next_ferr: got %0d expected 0", err_pulses); else passed++;
    endtask

    task automatic test_err_saturation();
        for (int k = 1; k <= 300; k++) begin
            send_frame(32'h1, 1);
            if (k == 254) begin
                checks++; if (errc_a !== 8'hFE) $display("FAIL sat_254: got %h expected FE", errc_a); else passed++;
            end
            if (k == 255) begin
                checks++; if (errc_a !== 8'hFF) $display("FAIL sat_255: got %h expected FF", errc_a); else passed++;
            end
        end
        checks++; if (errc_a !== 8'hFF)   $display("FAIL sat_300: got %h expected FF", errc_a); else passed++;
        checks++; if (act_a !== 16'h00C3) $display("FAIL sat_act: got %h expected 00C3", act_a); else passed++;
    endtask

    initial begin
        rst        = 1'b1;
        spck       = 1'b0;
        mosi       = 1'b0;
        ncs        = 1'b1;
        apply_safe = 1'b1;
        sel_b      = 1'b0;
        rx         = '0;
        snap5      = '0;
        err_pulses = 0;
        wait_clk(4);
        test_reset();
        rst = 1'b0;
        wait_clk(6);
        test_auto_write();
        test_manual_commit();
        test_rejects();
        test_readback();
        test_reset_mid_frame();
        test_err_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_spi_conf_regfile
`default_nettype wire
